// File: rtl/synch_fifo_pkg.sv
// Shared definitions for the synchronous FIFO family: read-mode constants
// and the modulo-DEPTH pointer increment used by every pointer counter.
package synch_fifo_pkg;

  localparam int FIFO_STD  = 0;  // registered read data
  localparam int FIFO_FWFT = 1;  // head word visible on rdata without a read

  // Next pointer value in a ring of 'depth' slots. The wrap uses an explicit
  // compare so non-power-of-two depths work.
  function automatic int unsigned ptr_inc(input int unsigned ptr,
                                          input int unsigned depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctr.sv
// Modulo-DEPTH pointer with enable and asynchronous active-high reset.
module fifo_ptr_ctr
  import synch_fifo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] ptr_q, ptr_d;

  // Advance by one slot when enabled, wrapping from DEPTH-1 to 0.
  always_comb begin
    ptr_d = ptr_q;
    if (en_i) ptr_d = PTR_W'(ptr_inc(32'(ptr_q), DEPTH));
  end

  // Pointer register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/synch_fifo_flex.sv
// Single-clock FIFO with arbitrary depth, registered fill count,
// programmable almost-full/almost-empty flags and selectable FWFT read mode.
module synch_fifo_flex
  import synch_fifo_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int DATA_WIDTH    = 12,
  parameter int FWFT          = FIFO_STD,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int CNT_WIDTH     = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic [CNT_WIDTH-1:0]  count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int PTR_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);

  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);
  localparam logic [CNT_WIDTH-1:0] AF_C    = CNT_WIDTH'(AFULL_THRESH);
  localparam logic [CNT_WIDTH-1:0] AE_C    = CNT_WIDTH'(AEMPTY_THRESH);

  // Elaboration-time guards on the parameter set.
  if (DEPTH < 2) begin : g_bad_depth
    $error("synch_fifo_flex: DEPTH must be >= 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("synch_fifo_flex: AFULL_THRESH must be in 1..DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
    $error("synch_fifo_flex: AEMPTY_THRESH must be in 0..DEPTH-1");
  end
  if (FWFT != FIFO_STD && FWFT != FIFO_FWFT) begin : g_bad_mode
    $error("synch_fifo_flex: FWFT must be 0 or 1");
  end
  if (CNT_WIDTH != $clog2(DEPTH + 1)) begin : g_bad_cnt
    $error("synch_fifo_flex: CNT_WIDTH is derived and must not be overridden");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  ovf_q, udf_q;
  logic                  rd_acc, wr_acc;

  // A full FIFO still takes a write when a read frees a slot the same cycle.
  assign rd_acc = rd_en_i && !empty_o;
  assign wr_acc = wr_en_i && (!full_o || rd_acc);

  fifo_ptr_ctr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (wr_acc),
    .ptr_o (wr_ptr)
  );

  fifo_ptr_ctr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (rd_acc),
    .ptr_o (rd_ptr)
  );

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (wr_acc) mem[wr_ptr] <= wdata_i;
  end

  // Occupancy next state: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  // Occupancy and rejected-request pulse registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= wr_en_i && !wr_acc;
      udf_q   <= rd_en_i && !rd_acc;
    end
  end

  // Status flags decode the count register alone, keeping them off any
  // input-to-output path.
  assign count_o        = count_q;
  assign full_o         = (count_q == DEPTH_C);
  assign empty_o        = (count_q == '0);
  assign almost_full_o  = (count_q >= AF_C);
  assign almost_empty_o = (count_q <= AE_C);
  assign overflow_o     = ovf_q;
  assign underflow_o    = udf_q;

  if (FWFT == FIFO_STD) begin : g_std
    logic [DATA_WIDTH-1:0] rdata_q;

    // Registered read port: loads the head word on an accepted read.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)       rdata_q <= '0;
      else if (rd_acc) rdata_q <= mem[rd_ptr];
    end

    assign rdata_o = rdata_q;
  end else begin : g_fwft
    // Head word shown directly; meaningful only while not empty.
    assign rdata_o = mem[rd_ptr];
  end

endmodule

// File: tb/tb_synch_fifo_flex.sv
// Bench for synch_fifo_flex: DEPTH=12 registered-read instance driven from a
// vector table and hand sequences against a queue model, plus a small FWFT
// instance exercised directly.
module tb_synch_fifo_flex;

  localparam int D  = 12;
  localparam int DW = 12;
  localparam int CW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0, rd_en = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          full, empty, afull, aempty, ovf, udf;
  logic [CW-1:0] count;

  logic          f_wr = 1'b0, f_rd = 1'b0;
  logic [DW-1:0] f_wd = '0;
  logic [DW-1:0] f_rdata;
  logic          f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
  logic [2:0]    f_count;

  always #5 clk = ~clk;

  synch_fifo_flex #(.DEPTH(D), .DATA_WIDTH(DW), .FWFT(0)) u_dut (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wdata_i(wdata),
    .rd_en_i(rd_en), .rdata_o(rdata), .full_o(full), .empty_o(empty),
    .almost_full_o(afull), .almost_empty_o(aempty), .count_o(count),
    .overflow_o(ovf), .underflow_o(udf)
  );

  synch_fifo_flex #(.DEPTH(4), .DATA_WIDTH(DW), .FWFT(1)) u_fwft (
    .clk_i(clk), .rst_i(rst), .wr_en_i(f_wr), .wdata_i(f_wd),
    .rd_en_i(f_rd), .rdata_o(f_rdata), .full_o(f_full), .empty_o(f_empty),
    .almost_full_o(f_afull), .almost_empty_o(f_aempty), .count_o(f_count),
    .overflow_o(f_ovf), .underflow_o(f_udf)
  );

  typedef struct {
    bit          wr;
    logic [11:0] wd;
    bit          rd;
    int          exp_count;
    bit          exp_ovf;
    bit          exp_udf;
  } vec_t;

  vec_t        tbl[$];
  logic [11:0] model_q[$];
  logic [11:0] exp_q[$];
  logic [11:0] last_rdata = '0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock of stimulus on the main instance, checked against the model.
  task automatic step(input bit wr, input logic [11:0] wd, input bit rd);
    bit racc, wacc;
    int sz;
    logic [11:0] e;
    sz   = model_q.size();
    racc = rd && (sz > 0);
    wacc = wr && ((sz < D) || racc);
    if (racc) exp_q.push_back(model_q.pop_front());
    if (wacc) model_q.push_back(wd);
    wr_en = wr; wdata = wd; rd_en = rd;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    sz = model_q.size();
    chk("count",  32'(count),  32'(sz));
    chk("full",   32'(full),   32'(sz == D));
    chk("empty",  32'(empty),  32'(sz == 0));
    chk("afull",  32'(afull),  32'(sz >= D - 2));
    chk("aempty", 32'(aempty), 32'(sz <= 2));
    chk("overflow",  32'(ovf), 32'(wr && !wacc));
    chk("underflow", 32'(udf), 32'(rd && !racc));
    if (racc) begin
      e = exp_q.pop_front();
      chk("rdata", 32'(rdata), 32'(e));
      last_rdata = e;
    end else begin
      chk("rdata_hold", 32'(rdata), 32'(last_rdata));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_count"},  32'(count),  32'd0);
    chk({tag, "_empty"},  32'(empty),  32'd1);
    chk({tag, "_full"},   32'(full),   32'd0);
    chk({tag, "_aempty"}, 32'(aempty), 32'd1);
    chk({tag, "_afull"},  32'(afull),  32'd0);
    chk({tag, "_ovf"},    32'(ovf),    32'd0);
    chk({tag, "_udf"},    32'(udf),    32'd0);
    chk({tag, "_rdata"},  32'(rdata),  32'd0);
  endtask

  initial begin
    // Vector table: fill, overflow, drain, underflow.
    for (int i = 0; i < 12; i++) tbl.push_back('{1'b1, 12'(i + 1), 1'b0, i + 1, 1'b0, 1'b0});
    for (int i = 0; i < 3;  i++) tbl.push_back('{1'b1, 12'(12'h0F0 + i), 1'b0, 12, 1'b1, 1'b0});
    for (int i = 0; i < 12; i++) tbl.push_back('{1'b0, 12'h000, 1'b1, 11 - i, 1'b0, 1'b0});
    for (int i = 0; i < 4;  i++) tbl.push_back('{1'b0, 12'h000, 1'b1, 0, 1'b0, 1'b1});

    #12;
    check_reset_outputs("reset");
    chk("reset_fwft_empty", 32'(f_empty), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (tbl[k]) begin
      step(tbl[k].wr, tbl[k].wd, tbl[k].rd);
      chk("tbl_count", 32'(count), 32'(tbl[k].exp_count));
      chk("tbl_ovf",   32'(ovf),   32'(tbl[k].exp_ovf));
      chk("tbl_udf",   32'(udf),   32'(tbl[k].exp_udf));
    end

    // Write on empty with a read: write taken, read rejected.
    step(1'b1, 12'h3C3, 1'b1);
    step(1'b0, 12'h000, 1'b1);

    // Full FIFO, 20 cycles of simultaneous push/pop: pointers wrap.
    for (int i = 0; i < D; i++) step(1'b1, 12'(12'h100 + i), 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 12'(12'h200 + i), 1'b1);
    for (int i = 0; i < D; i++) step(1'b0, 12'h000, 1'b1);

    // Fill to 7 then hit reset between edges.
    for (int i = 0; i < 7; i++) step(1'b1, 12'(12'h300 + i), 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    wr_en = 1'b1; wdata = 12'h777;
    @(posedge clk); #1;
    wr_en = 1'b0;
    check_reset_outputs("rsthold");
    rst = 1'b0;
    model_q.delete();
    exp_q.delete();
    last_rdata = '0;
    step(1'b1, 12'h5A5, 1'b0);
    step(1'b0, 12'h000, 1'b1);
    step(1'b0, 12'h000, 1'b1);

    // FWFT: head word visible without a read, read pops.
    f_wr = 1'b1; f_wd = 12'hABC;
    @(posedge clk); #1;
    f_wr = 1'b0;
    chk("fwft_rdata",  32'(f_rdata), 32'hABC);
    chk("fwft_nempty", 32'(f_empty), 32'd0);
    @(posedge clk); #1;
    chk("fwft_rdata_hold", 32'(f_rdata), 32'hABC);
    chk("fwft_count1",     32'(f_count), 32'd1);
    f_rd = 1'b1;
    @(posedge clk); #1;
    f_rd = 1'b0;
    chk("fwft_empty", 32'(f_empty), 32'd1);
    chk("fwft_count0", 32'(f_count), 32'd0);
    chk("fwft_udf0",  32'(f_udf),   32'd0);
    f_wr = 1'b1; f_wd = 12'h111;
    @(posedge clk); #1;
    f_wd = 12'h222;
    @(posedge clk); #1;
    f_wr = 1'b0;
    chk("fwft_head1", 32'(f_rdata), 32'h111);
    f_rd = 1'b1;
    @(posedge clk); #1;
    f_rd = 1'b0;
    chk("fwft_head2", 32'(f_rdata), 32'h222);
    chk("fwft_count_after", 32'(f_count), 32'd1);
    f_rd = 1'b1;
    @(posedge clk); #1;
    f_rd = 1'b0;
    chk("fwft_empty2", 32'(f_empty), 32'd1);
    chk("fwft_full",   32'(f_full),  32'd0);
    chk("fwft_ovf",    32'(f_ovf),   32'd0);
    chk("fwft_aflags", 32'({f_afull, f_aempty}), 32'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
